// File: rtl/axi_r_burst_arbiter.sv
// -----------------------------------------------------------------------------
// axi_r_burst_arbiter
//
// Round-robin arbiter sharing one AXI read-data (R) return channel among
// N_INIT_PORT response sources. The winning source's beat is muxed
// combinationally onto the output, and the downstream ready is routed back
// only to that source.
//
// Build option (macro AXI_R_ARB_BURST_LOCK_EN):
//   defined   - a grant is held from the first beat until the rlast handshake,
//               so bursts from different sources never interleave.
//   undefined - per-beat arbitration. The grant is held only across a stalled
//               beat (rvalid_o & !rready_i) and moves on after every handshake.
// In both builds a presented beat keeps its source until it is accepted.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   rvalid_i/rready_o  per-source handshake
//   rid_i, rdata_i, rresp_i, rlast_i, ruser_i   per-source beat payload
//   rid_o, rdata_o, rresp_o, rlast_o, ruser_o   granted beat payload
//   rvalid_o/rready_i  downstream handshake
//   sel_o              index of the currently granted source
//   locked_o           high while the grant is held (LOCKED state)
//   beat_cnt_o         beats accepted so far in the current burst, saturating
//                      at 255
// -----------------------------------------------------------------------------
module axi_r_burst_arbiter #(
    parameter int N_INIT_PORT = 4,
    parameter int AXI_ID_IN   = 16,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int LOG_N_INIT  = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_INIT_PORT-1:0]                  rvalid_i,
    output logic [N_INIT_PORT-1:0]                  rready_o,
    input  logic [N_INIT_PORT-1:0][AXI_ID_IN-1:0]   rid_i,
    input  logic [N_INIT_PORT-1:0][AXI_DATA_W-1:0]  rdata_i,
    input  logic [N_INIT_PORT-1:0][1:0]             rresp_i,
    input  logic [N_INIT_PORT-1:0]                  rlast_i,
    input  logic [N_INIT_PORT-1:0][AXI_USER_W-1:0]  ruser_i,
    output logic [AXI_ID_IN-1:0]                    rid_o,
    output logic [AXI_DATA_W-1:0]                   rdata_o,
    output logic [1:0]                              rresp_o,
    output logic                                    rlast_o,
    output logic [AXI_USER_W-1:0]                   ruser_o,
    output logic                                    rvalid_o,
    input  logic                                    rready_i,
    output logic [LOG_N_INIT-1:0]                   sel_o,
    output logic                                    locked_o,
    output logic [7:0]                              beat_cnt_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [LOG_N_INIT-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LOG_N_INIT-1:0]  sel_q, sel_d;
    logic [7:0]             beat_cnt_q, beat_cnt_d;

    logic [LOG_N_INIT-1:0]  cand;
    logic                   cand_vld;
    logic                   hs;
    logic                   last_hs;

    // Next index after idx, wrapping to 0 past the last source.
    function automatic logic [LOG_N_INIT-1:0] wrap_inc(input logic [LOG_N_INIT-1:0] idx);
        if (int'(idx) >= N_INIT_PORT - 1) begin
            return '0;
        end
        return LOG_N_INIT'(int'(idx) + 1);
    endfunction

    // -------------------------------------------------------------------------
    // Candidate selection
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int scan;
        cand     = rr_ptr_q;
        cand_vld = 1'b0;
        scan     = 0;
        if (state_q == LOCKED) begin
            // The held grant ignores every other source's valid.
            cand     = sel_q;
            cand_vld = rvalid_i[sel_q];
        end else begin
            // Scan from the farthest offset down to rr_ptr itself so the last
            // hit written is the nearest one at or after rr_ptr.
            for (int k = N_INIT_PORT - 1; k >= 0; k--) begin
                scan = int'(rr_ptr_q) + k;
                if (scan >= N_INIT_PORT) begin
                    scan = scan - N_INIT_PORT;
                end
                if (rvalid_i[LOG_N_INIT'(scan)]) begin
                    cand     = LOG_N_INIT'(scan);
                    cand_vld = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output mux and ready steering
    // -------------------------------------------------------------------------
    always_comb begin
        rid_o    = rid_i[cand];
        rdata_o  = rdata_i[cand];
        rresp_o  = rresp_i[cand];
        rlast_o  = rlast_i[cand];
        ruser_o  = ruser_i[cand];
        // NOTE: rst_n gates the handshake outputs directly, so nothing is
        // offered or accepted while reset is asserted, even before a clock edge.
        rvalid_o = cand_vld & rst_n;
        rready_o = '0;
        if (rst_n && (cand_vld || state_q == LOCKED)) begin
            rready_o[cand] = rready_i;
        end
    end

    assign hs      = rvalid_o & rready_i;
    assign last_hs = hs & rlast_o;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        beat_cnt_d = beat_cnt_q;

        if (hs) begin
            if (rlast_o) begin
                beat_cnt_d = '0;
            end else if (beat_cnt_q != 8'hFF) begin
                beat_cnt_d = beat_cnt_q + 8'd1;
            end
        end

`ifdef AXI_R_ARB_BURST_LOCK_EN
        // Burst lock: any beat that does not close its burst in the same cycle
        // (a stalled beat, or an accepted non-last beat) pins the grant.
        unique case (state_q)
            IDLE: begin
                if (last_hs) begin
                    rr_ptr_d = wrap_inc(cand);
                end else if (rvalid_o) begin
                    state_d = LOCKED;
                    sel_d   = cand;
                end
            end
            LOCKED: begin
                if (last_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = wrap_inc(sel_q);
                end
            end
            default: state_d = IDLE;
        endcase
`else
        // Per-beat arbitration: only a stalled beat pins the grant, and the
        // pointer advances past the winner after every accepted beat.
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    rr_ptr_d = wrap_inc(cand);
                end else if (rvalid_o) begin
                    state_d = LOCKED;
                    sel_d   = cand;
                end
            end
            LOCKED: begin
                if (hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = wrap_inc(sel_q);
                end
            end
            default: state_d = IDLE;
        endcase
`endif
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign sel_o      = cand;
    assign locked_o   = (state_q == LOCKED);
    assign beat_cnt_o = beat_cnt_q;

endmodule

// File: doc/axi_r_burst_arbiter.md
# axi_R_burst_arbiter

Round-robin arbiter that shares one AXI read-data (R) return channel among N_INIT_PORT initiator-side response sources. It sits in front of the read backward allocator in the AXI node. A grant, once given, is held until the burst's `rlast` beat completes, so bursts from different sources never interleave. Any beat already presented downstream stays stable until it is accepted.

## Interface
- `N_INIT_PORT`, default 4: number of competing R sources (≥1).
- `AXI_ID_IN`, default 16: ID width on inputs and output.
- `AXI_DATA_W`, default 64: data width.
- `AXI_USER_W`, default 6: user width.
- `LOG_N_INIT`, default max(1, $clog2(N_INIT_PORT)): selector width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rvalid_i`  in  [N_INIT_PORT]  per-source beat valid.
- `rready_o`  out  [N_INIT_PORT]  per-source ready.
- `rid_i`, `rdata_i`, `rresp_i`[1:0], `rlast_i`, `ruser_i`  in  [N_INIT_PORT][width]  per-source beat payload.
- `rid_o`, `rdata_o`, `rresp_o`, `rlast_o`, `ruser_o`  out  width  granted beat payload.
- `rvalid_o`  out  1  granted beat valid.
- `rready_i`  in  1  downstream ready.
- `sel_o`  out  LOG_N_INIT  index of the currently granted source.
- `locked_o`  out  1  high while in the LOCKED state.
- `beat_cnt_o`  out  8  beats accepted so far in the current burst; saturates at 255.

## Operation
**State and reset**
- Registered state: `state` ∈ {IDLE, LOCKED}, `rr_ptr`, `sel_q`, `beat_cnt`.
- All of these reset to IDLE / 0.

**Grant selection**
- In IDLE, the candidate is the first `i` with `rvalid_i[i]=1`, scanning from `rr_ptr` upward and wrapping modulo N_INIT_PORT.
- In LOCKED, the candidate is `sel_q` regardless of any other valid.
- `sel_o` = candidate. In IDLE with no valid input, `sel_o` = `rr_ptr`.

**Output mux**
- Payload outputs, `rvalid_o` and `rlast_o` come combinationally from the candidate source.
- `rvalid_o` = 0 when there is no candidate.
- `rready_o[candidate]` = `rready_i`; all other `rready_o` bits = 0.
- Handshake `hs` = `rvalid_o & rready_i`.

**Transitions**
- IDLE → LOCKED when `rvalid_o & !(hs & rlast_o)`; `sel_q` ← candidate.
- IDLE → IDLE on `hs & rlast_o` (single-beat burst); `rr_ptr` ← candidate+1 (wraps).
- LOCKED → IDLE on `hs & rlast_o`; `rr_ptr` ← `sel_q`+1 (wraps).
- LOCKED is otherwise held, including cycles where the locked source drops `rvalid_i` (a protocol violation; the grant still does not move).

**Beat counter**
- `beat_cnt` increments on `hs & !rlast_o`, saturating at 255.
- `beat_cnt` clears to 0 on `hs & rlast_o`.

**Degenerate case**
- With N_INIT_PORT=1 the block is a pass-through plus state tracking; `rr_ptr` stays 0.

## Timing
- Zero-cycle payload latency: input to output is combinational. `rready_i` to `rready_o` is combinational.
- Grant changes only on a clock edge following `hs & rlast_o`, or in IDLE when `rvalid_o` = 0.
- A beat with `rvalid_o` = 1 and `rready_i` = 0 keeps the same source on the next cycle. This meets the AXI stability rule.
- Simultaneous requests in IDLE: the lowest index at or after `rr_ptr` (modulo) wins.
- Reset asserted mid-burst: the state returns to IDLE immediately, `rready_o` = 0, and all in-flight lock information is discarded.
- No combinational path exists from `rvalid_i` to `rready_o` of a different source while LOCKED.

## Configuration
- `AXI_R_ARB_BURST_LOCK_EN` defined: behaviour is exactly as above, with the grant held for the whole burst.
- `AXI_R_ARB_BURST_LOCK_EN` undefined: per-beat arbitration.
  - IDLE → LOCKED only on `rvalid_o & !rready_i` (stall hold).
  - LOCKED → IDLE on any `hs`.
  - `rr_ptr` ← granted index + 1 after every handshake beat.
  - `beat_cnt` is still tracked per accepted beat.

## Test plan
- Reset with all `rvalid_i`=1 → `rvalid_o`=0 and all `rready_o`=0 during reset. After release, source 0 is granted and `sel_o`=0.
- N=4: sources 1 and 3 each issue a 4-beat burst simultaneously, `rready_i`=1 → four beats from source 1 (`beat_cnt_o` 0,1,2,3), then four from source 3, with no interleave; `rr_ptr` ends at 0.
- Source 2 beat with `rready_i`=0 for 5 cycles while source 0 raises valid → `sel_o`=2 and payload are stable all 5 cycles; source 0 is served only after source 2's `rlast`.
- All four sources issue single-beat bursts repeatedly → grant order is 0,1,2,3,0,… with one beat per cycle and `locked_o` never high.
- A 300-beat burst → `beat_cnt_o` saturates at 255 and clears to 0 after the `rlast` handshake.
- Build with the macro undefined, sources 0 and 1 each issuing 2-beat bursts → beats alternate 0,1,0,1.
